// File: rtl/note_pkg.sv
// Shared constants and types for the note playback engine.
package note_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    // Note word layout: bit index = fret*6 + string, fret 0 is the open string.
    localparam int unsigned NUM_STRINGS = 6;
    localparam int unsigned NUM_FRETS   = 5;
    localparam int unsigned MAX_NOTES   = 64;

    // Bits 31:30 of a note word are never driven to the audio path.
    localparam logic [31:0] NOTE_MASK = 32'h3FFF_FFFF;

    // Note period in clock cycles for speed 0..7 (index 0 is the slowest tempo).
    localparam int unsigned NUM_TEMPOS = 8;
    localparam logic [NUM_TEMPOS-1:0][31:0] TEMPO_TABLE = {
        32'd13636364, 32'd16666667, 32'd21428571, 32'd25000000,
        32'd30000000, 32'd37500000, 32'd50000000, 32'd75000000
    };

    // Lengths above the RAM depth play the whole RAM.
    function automatic logic [6:0] clamp_length(input logic [6:0] len);
        return (len > 7'd64) ? 7'd64 : len;
    endfunction

endpackage

// File: rtl/tempo_timer.sv
// Loadable down counter that times one note and gates the envelope off
// during the last GAP_CYCLES cycles of the note period.
module tempo_timer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned GAP_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    output logic             expire,
    output logic             gate
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             running_q, running_d;

    // Next count: clear wins, a load restarts the note, otherwise count down to zero and stop.
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        if (clear) begin
            count_d   = '0;
            running_d = 1'b0;
        end else if (load) begin
            count_d   = period - CNT_W'(1);
            running_d = 1'b1;
        end else if (running_q) begin
            if (count_q == '0) begin
                running_d = 1'b0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    assign expire = running_q && (count_q == '0);
    assign gate   = running_q && (count_q >= CNT_W'(GAP_CYCLES));

endmodule

// File: rtl/note_player.sv
// Playback engine: walks the note RAM at the selected tempo and presents each
// word to the audio module with a valid strobe and a gated envelope.
module note_player
    import note_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned TEMPO_DIV   = 1,
    parameter int unsigned GAP_CYCLES  = 10000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [2:0]        speed,
    input  logic [6:0]        length,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] note,
    output logic              note_valid,
    output logic              gate,
    output logic              playing,
    output logic              done,
    output logic [2:0]        state
);

    localparam int unsigned FCW = (RAM_LATENCY < 1) ? 1 : $clog2(RAM_LATENCY + 1);

    // Tempo periods pre-divided at elaboration so no divider is built.
    localparam logic [NUM_TEMPOS-1:0][31:0] PERIOD_TABLE = {
        TEMPO_TABLE[7] / TEMPO_DIV, TEMPO_TABLE[6] / TEMPO_DIV,
        TEMPO_TABLE[5] / TEMPO_DIV, TEMPO_TABLE[4] / TEMPO_DIV,
        TEMPO_TABLE[3] / TEMPO_DIV, TEMPO_TABLE[2] / TEMPO_DIV,
        TEMPO_TABLE[1] / TEMPO_DIV, TEMPO_TABLE[0] / TEMPO_DIV
    };

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
    logic [DATA_W-1:0]  note_q, note_d;
    logic               note_valid_q, note_valid_d;
    logic [FCW-1:0]     fetch_cnt_q, fetch_cnt_d;
    logic               start_prev_q, start_prev_d;

    logic               start_edge;
    logic [6:0]         len_clamped;
    logic [6:0]         next_index;
    logic [31:0]        period;
    logic               timer_load;
    logic               timer_clear;
    logic               timer_expire;
    logic               timer_gate;

    assign start_edge  = start && !start_prev_q;
    assign len_clamped = clamp_length(length);
    assign next_index  = 7'(index_q) + 7'd1;
    assign period      = PERIOD_TABLE[speed];

    tempo_timer #(
        .CNT_W      (32),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_tempo_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (timer_clear),
        .load   (timer_load),
        .period (period),
        .expire (timer_expire),
        .gate   (timer_gate)
    );

    // Next-state and datapath control; stop overrides everything and aborts without a done pulse.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        ram_address_d = ram_address_q;
        note_d        = note_q;
        note_valid_d  = 1'b0;
        fetch_cnt_d   = fetch_cnt_q;
        start_prev_d  = start;
        timer_load    = 1'b0;
        timer_clear   = 1'b0;

        if (stop) begin
            state_d       = ST_IDLE;
            index_d       = '0;
            ram_address_d = '0;
            note_d        = '0;
            fetch_cnt_d   = '0;
            timer_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        if (len_clamped != 7'd0) begin
                            state_d       = ST_FETCH;
                            index_d       = '0;
                            ram_address_d = '0;
                            fetch_cnt_d   = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    ram_address_d = index_q;
                    if (fetch_cnt_q == FCW'(RAM_LATENCY)) begin
                        note_d       = ram_q & NOTE_MASK[DATA_W-1:0];
                        note_valid_d = 1'b1;
                        timer_load   = 1'b1;
                        fetch_cnt_d  = '0;
                        state_d      = ST_PLAY;
                    end else begin
                        fetch_cnt_d = fetch_cnt_q + FCW'(1);
                    end
                end
                ST_PLAY: begin
                    if (timer_expire) begin
                        if (next_index < len_clamped) begin
                            index_d       = ADDR_W'(next_index);
                            ram_address_d = ADDR_W'(next_index);
                            fetch_cnt_d   = '0;
                            state_d       = ST_FETCH;
                        end else if (loop_en) begin
                            index_d       = '0;
                            ram_address_d = '0;
                            fetch_cnt_d   = '0;
                            state_d       = ST_FETCH;
                        end else begin
                            note_d  = '0;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    note_d  = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            ram_address_q <= '0;
            note_q        <= '0;
            note_valid_q  <= 1'b0;
            fetch_cnt_q   <= '0;
            start_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            ram_address_q <= ram_address_d;
            note_q        <= note_d;
            note_valid_q  <= note_valid_d;
            fetch_cnt_q   <= fetch_cnt_d;
            start_prev_q  <= start_prev_d;
        end
    end

    assign ram_address = ram_address_q;
    assign note        = note_q;
    assign note_valid  = note_valid_q;
    assign gate        = timer_gate && (state_q == ST_PLAY);
    assign playing     = (state_q == ST_FETCH) || (state_q == ST_PLAY);
    assign done        = (state_q == ST_DONE);
    assign state       = state_q;

endmodule
